// File: rtl/osc_tick_pkg.sv
// rtl/osc_tick_pkg.sv - shared types, limits and divisor clamp for the tick generator
package osc_tick_pkg;

    // Channel datapath is sized for the widest supported divisor; narrower
    // configurations zero-extend into it.
    localparam int DIV_W_MAX = 32;

    typedef logic [DIV_W_MAX-1:0] div_t;

    localparam div_t DIV_MIN = div_t'(2);
    localparam div_t DIV_ONE = div_t'(1);

    typedef struct packed {
        div_t cnt;
        div_t div;
        div_t pdiv;
        logic en;
        logic pend;
    } chan_state_t;

    function automatic div_t clamp_div(input div_t d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/osc_tick_chan.sv
// rtl/osc_tick_chan.sv - one channel: down-counter, shadow divisor, tick/sq decode
module osc_tick_chan
    import osc_tick_pkg::*;
#(
    parameter int   DIV_W   = 16,
    parameter int   DEF_DIV = 100,
    parameter logic RST_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    input  logic             wr_en_i,
    input  logic             sync_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pend_o
);

    localparam div_t DEF_CL = clamp_div(div_t'(DEF_DIV));

    chan_state_t state_q;
    chan_state_t state_d;
    div_t        wr_div_c;
    div_t        div_eff;

    always_comb begin
        state_d  = state_q;
        wr_div_c = clamp_div(div_t'(wr_div_i));
        div_eff  = '0;

        if (state_q.en) begin
            if (state_q.cnt == '0) begin
                if (state_q.pend) begin
                    state_d.div  = state_q.pdiv;
                    state_d.pend = 1'b0;
                end
                state_d.cnt = state_d.div - DIV_ONE;
            end else begin
                state_d.cnt = state_q.cnt - DIV_ONE;
            end
        end

        // A write landing on the reload cycle bypasses the shadow register.
        if (wr_i) begin
            if (!wr_en_i) begin
                state_d.en   = 1'b0;
                state_d.pend = 1'b0;
                state_d.cnt  = '0;
            end else if (!state_q.en || state_q.cnt == '0) begin
                state_d.en   = 1'b1;
                state_d.div  = wr_div_c;
                state_d.cnt  = wr_div_c - DIV_ONE;
                state_d.pend = 1'b0;
            end else begin
                state_d.pdiv = wr_div_c;
                state_d.pend = 1'b1;
            end
        end

        if (sync_i && state_d.en) begin
            div_eff      = state_d.pend ? state_d.pdiv : state_d.div;
            state_d.div  = div_eff;
            state_d.cnt  = div_eff - DIV_ONE;
            state_d.pend = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q.cnt  <= DEF_CL - DIV_ONE;
            state_q.div  <= DEF_CL;
            state_q.pdiv <= DEF_CL;
            state_q.en   <= RST_EN;
            state_q.pend <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign tick_o = state_q.en && (state_q.cnt == '0);
    assign sq_o   = state_q.en && (state_q.cnt >= (state_q.div >> 1));
    assign pend_o = state_q.pend;

endmodule

// File: rtl/osc_tick_gen.sv
// rtl/osc_tick_gen.sv - NCH programmable tick/square-wave generator with config port and sync
module osc_tick_gen
    import osc_tick_pkg::*;
#(
    parameter int             NCH     = 4,
    parameter int             DIV_W   = 16,
    parameter int             DEF_DIV = 100,
    parameter logic [NCH-1:0] RST_EN  = {NCH{1'b1}},
    localparam int            CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             sync,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr;

    // Out-of-range channel numbers always see ready and their writes vanish.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        osc_tick_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .RST_EN  (RST_EN[g])
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .wr_i     (wr[g]),
            .wr_div_i (cfg_div),
            .wr_en_i  (cfg_en),
            .sync_i   (sync),
            .tick_o   (tick[g]),
            .sq_o     (sq[g]),
            .pend_o   (pend[g])
        );
    end

endmodule

// File: tb/tb_osc_tick_gen.sv
// tb/tb_osc_tick_gen.sv - directed and randomized bench against an absolute-time reference model
module tb_osc_tick_gen;

    localparam int NCH     = 5;
    localparam int DIV_W   = 16;
    localparam int DEF_DIV = 100;
    localparam int CH_W    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_en = 1'b0;
    logic             sync = 1'b0;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   sq;

    osc_tick_gen #(
        .NCH     (NCH),
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV),
        .RST_EN  (5'b11111)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .sync      (sync),
        .tick      (tick),
        .sq        (sq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;
    bit mvalid = 1'b0;
    logic [NCH-1:0] last_tick;

    // Model: per channel, the period, the absolute cycle of the next tick,
    // and an optional pending period.
    bit m_en[NCH];
    int m_per[NCH];
    int m_nxt[NCH];
    int m_pper[NCH];
    bit m_pend[NCH];

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic bit exp_ready(input int ch);
        return (ch >= NCH) || !m_pend[ch];
    endfunction

    task automatic check_vec(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed %b expected %b", tag, t, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit acc, input int ch, input int dv, input bit e, input bit s, input bit r);
        bit tk;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin
                m_en[i] = 1'b1; m_per[i] = DEF_DIV; m_nxt[i] = t + DEF_DIV;
                m_pper[i] = DEF_DIV; m_pend[i] = 1'b0;
            end
            mvalid = 1'b1;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            tk = m_en[i] && (m_nxt[i] == t);
            if (tk) begin
                if (m_pend[i]) begin m_per[i] = m_pper[i]; m_pend[i] = 1'b0; end
                m_nxt[i] = t + m_per[i];
            end
            if (acc && ch == i) begin
                if (!e) begin
                    m_en[i] = 1'b0; m_pend[i] = 1'b0;
                end else if (!m_en[i] || tk) begin
                    m_en[i] = 1'b1; m_per[i] = clampd(dv); m_nxt[i] = t + m_per[i];
                end else begin
                    m_pper[i] = clampd(dv); m_pend[i] = 1'b1;
                end
            end
            if (s && m_en[i]) begin
                if (m_pend[i]) begin m_per[i] = m_pper[i]; m_pend[i] = 1'b0; end
                m_nxt[i] = t + m_per[i];
            end
        end
    endtask

    task automatic step(input bit v, input int ch, input int dv, input bit e, input bit s, input bit r, output bit acc);
        logic [NCH-1:0] et;
        logic [NCH-1:0] es;
        logic [0:0] er;
        @(negedge clk);
        cfg_valid = v; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(dv); cfg_en = e; sync = s; rst = r;
        #1;
        last_tick = tick;
        if (mvalid) begin
            for (int i = 0; i < NCH; i++) begin
                et[i] = m_en[i] && (m_nxt[i] == t);
                es[i] = m_en[i] && ((m_nxt[i] - t) >= (m_per[i] / 2));
            end
            er[0] = exp_ready(ch);
            check_vec("tick", tick, et);
            check_vec("sq", sq, es);
            check_vec("cfg_ready", {{(NCH-1){1'b0}}, cfg_ready}, {{(NCH-1){1'b0}}, er[0]});
        end
        acc = v && exp_ready(ch);
        model_update(acc, ch, dv, e, s, r);
        t++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic cfg_write(input int ch, input int dv, input bit e, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 400) begin
            step(1'b1, ch, dv, e, 1'b0, 1'b0, acc);
            if (!acc) waited++;
        end
        if (!acc) begin
            checks++; errors++;
            $error("FAIL cfg_write_timeout ch=%0d observed 0 expected 1", ch);
        end
    endtask

    task automatic wait_rem(input int ch, input int r);
        for (int k = 0; k < 400 && !(m_en[ch] && (m_nxt[ch] - t) == r); k++) idle(1);
        if (!(m_en[ch] && (m_nxt[ch] - t) == r)) begin
            checks++; errors++;
            $error("FAIL wait_rem ch=%0d observed %0d expected %0d", ch, m_nxt[ch] - t, r);
        end
    endtask

    initial begin
        bit acc;
        bit busy;
        int w;
        int k;
        int rc, rd;
        bit re, rs, rr;

        // Reset defaults and first-tick latency.
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
        k = -1;
        for (int i = 0; i < 200 && k < 0; i++) begin
            idle(1);
            if (last_tick[0]) k = i;
        end
        check_int("first_tick_cycle", k, 99);
        idle(110);

        // Boundary reconfiguration on ch1 and backpressure of a second write.
        wait_rem(1, 40);
        cfg_write(1, 10, 1'b1, w);
        cfg_write(1, 50, 1'b1, w);
        check_int("ch1_stall_cycles", w, 40);
        idle(30);

        // Immediate disable and re-enable on ch2.
        cfg_write(2, 33, 1'b0, w);
        idle(5 + $urandom_range(0, 9));
        cfg_write(2, 7, 1'b1, w);
        idle(30);

        // Clamp and odd divisors on ch3.
        cfg_write(3, 0, 1'b1, w);
        cfg_write(3, 1, 1'b1, w);
        idle(10);
        cfg_write(3, 5, 1'b1, w);
        idle(20);

        // Sync alignment of ch0 and ch1.
        cfg_write(0, 8, 1'b1, w);
        cfg_write(1, 12, 1'b1, w);
        idle($urandom_range(3, 40));
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
        k = -1;
        for (int i = 1; i < 40 && k < 0; i++) begin
            idle(1);
            if (last_tick[1]) k = i;
        end
        check_int("sync_to_ch1_tick", k, 12);
        idle(50);

        // Write accepted exactly on the reload cycle.
        wait_rem(0, 0);
        cfg_write(0, 20, 1'b1, w);
        check_int("zero_cnt_no_stall", w, 0);
        idle(45);

        // Out-of-range channel numbers are accepted and dropped.
        for (int c = NCH; c < 8; c++) begin
            cfg_write(c, 3, 1'b0, w);
            check_int("oor_ch_accept", w, 0);
        end
        idle(30);

        // Reset while an update is pending.
        wait_rem(4, 60);
        cfg_write(4, 30, 1'b1, w);
        idle(3);
        step(1'b0, 4, 0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 4, 0, 1'b0, 1'b0, 1'b0, acc);
        idle(120);

        // Randomized soak with overlapping writes, syncs and rare resets.
        busy = 1'b0; rc = 0; rd = 0; re = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!busy && $urandom_range(0, 5) == 0) begin
                busy = 1'b1;
                rc = $urandom_range(0, 7);
                rd = $urandom_range(0, 40);
                re = ($urandom_range(0, 5) != 0);
            end
            rs = ($urandom_range(0, 39) == 0);
            rr = ($urandom_range(0, 799) == 0);
            step(busy, rc, rd, re, rs, rr, acc);
            if (acc) busy = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_tick_gen.md
Name: osc_tick_gen

Overview:
- Parametrised successor to the fixed-divide on-chip oscillator block in the delay-generation path.
- Runs from the oscillator output clock. Produces NCH independent, runtime-programmable tick strobes and square waves.
- Each channel's divisor and enable are written over a valid/ready config port. Divisor changes take effect only at a period boundary, so no runt periods occur.
- A global sync pulse phase-aligns all channels for TDC/ADC trigger timing.

Parameters:
- NCH, 4: number of output channels (1..16).
- DIV_W, 16: divisor width in bits.
- DEF_DIV, 100: divisor loaded into every channel at reset.
- RST_EN, {NCH{1'b1}}: per-channel enable value at reset.

Ports:
- clk  in  1  oscillator clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; a transfer occurs when cfg_valid && cfg_ready.
- cfg_ch  in  max(1,$clog2(NCH))  target channel; values >= NCH are accepted and dropped.
- cfg_div  in  DIV_W  new divisor (period in clk cycles).
- cfg_en  in  1  new enable for the target channel.
- sync  in  1  single-cycle pulse; restarts all enabled channels.
- tick  out  NCH  one-cycle strobe per channel period.
- sq  out  NCH  square wave per channel.

Behaviour:
- One clock domain; synchronous, active-high reset.
- Per-channel state:
  - cnt[DIV_W]: down-counter.
  - div[DIV_W]: active divisor.
  - en: channel enable.
  - pend: pending-update flag.
  - pdiv: pending divisor.
- Reset: div=DEF_DIV, cnt=DEF_DIV-1, en=RST_EN[i], pend=0, cfg_ready=1, tick=0, sq=0.
- Outputs are decoded from state registers only; there is no combinational path from any input to tick or sq.
- Divisor clamp: any divisor < 2 (from cfg_div, or DEF_DIV < 2) is stored as 2. No period is shorter than 2 cycles.
- Counting (en=1): cnt decrements each cycle. At cnt==0 it reloads to div-1.
  - tick[i]=en && cnt==0.
  - sq[i]=en && cnt >= div>>1, i.e. high for ceil(div/2) cycles, starting at the reload.
- First tick after reset occurs in cycle DEF_DIV-1, counting the first cycle with rst low as cycle 0. Ticks then repeat every DEF_DIV cycles.
- Disabled channel (en=0): cnt is held at 0; tick=0 and sq=0.
- Config write, resolved by the state of the target channel:
  - en=0 in the write: applies immediately. Next cycle en=0 and pend is cleared.
  - Target disabled, en=1 in the write: applies immediately. div=clamp(cfg_div), cnt=div-1, en=1. First tick occurs div cycles after the accept cycle.
  - Target enabled, en=1 in the write, cnt!=0: pdiv=clamp(cfg_div), pend=1. At the next cnt==0 cycle, tick still fires, div<=pdiv, cnt<=pdiv-1, pend<=0.
  - Target enabled, en=1 in the write, cnt==0 in the accept cycle: this cycle's tick fires, and the reload uses the new divisor directly with no pending stage.
- cfg_ready = !pend[cfg_ch]. At most one pending update per channel; further writes to that channel are backpressured until the boundary.
  - cfg_ready depends combinationally on cfg_ch. Masters must hold cfg_ch stable while valid.
- sync: every enabled channel gets cnt<=div_eff-1 and pend<=0 next cycle.
  - div_eff is pdiv if pend, otherwise div.
  - A config write accepted in the same cycle is applied first; sync then uses the resulting divisor.
  - The tick/sq outputs of the sync cycle itself are unaffected.
- Simultaneous sync and cnt==0: the tick fires, and the reload is as for sync. The result is identical to a normal reload.
- rst asserted mid-operation: all state returns to reset values the next cycle, and pending updates are discarded.

Decomposition:
- osc_tick_pkg holds:
  - DIV_MIN=2.
  - A clamp function for divisors.
  - Channel state struct typedef {cnt, div, pdiv, en, pend}.
- Sub-module osc_tick_chan: one channel's counter, shadow register, and tick/sq decode, with inputs wr, wr_div, wr_en, sync.
- The top level holds:
  - The channel-select decode.
  - The cfg_ready mux.
  - A generate loop instantiating NCH osc_tick_chan.

Test Plan:
- Reset defaults: rst 3 cycles then release, defaults -> tick[0] high in cycle 99 and then every 100 cycles; sq[0] high for 50 cycles after each reload; cfg_ready=1.
- Boundary reconfig: ch1 enabled at div=100, write div=10 at cnt=40 -> cfg_ready low for 40 cycles. Tick fires at the old boundary, next tick 10 cycles later. A second write to ch1 is stalled until the boundary.
- Immediate disable/enable: write ch2 en=0 -> tick[2] and sq[2] low from the next cycle. Write ch2 div=7 en=1 -> tick at 7, 14, 21 cycles after accept.
- Clamp and odd divisor: write div=0 and then div=1 -> period 2, sq toggles every cycle. Write div=5 -> sq high 3 cycles, low 2.
- Sync alignment: ch0 div=8, ch1 div=12 at arbitrary phases, pulse sync -> both tick exactly 8 and 12 cycles after the sync cycle, then every 24 cycles in coincidence.
- Corner cases:
  - Write accepted exactly at cnt==0 -> the old tick fires, and the new period starts immediately with no pending stage.
  - cfg_ch=NCH -> accepted and dropped, with no state change.
  - rst while pend=1 -> pend cleared, div=DEF_DIV.
